spi_note_receiver: RTL and testbench

SPI_NOTE_RECEIVER -- requirements
Module: spi_note_receiver

---
 rtl/synth_pkg.sv | 39 +++
 rtl/spi_input_sync.sv | 37 +++
 rtl/spi_note_receiver.sv | 120 ++++++++++++
 tb/tb_spi_note_receiver.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and frame layout for the SPI note receiver.
// Define SPI_NOTE_RX_CHECKSUM_EN to append an XOR checksum byte to each frame.
package synth_pkg;

    localparam int TUNING_W = 32;
    localparam int VOICE_W  = 8;
    localparam int VEL_W    = 7;

    localparam int BYTE_CTRL  = 0;
    localparam int BYTE_VOICE = 1;
    localparam int BYTE_TUNE  = 2;
    localparam int BYTE_CSUM  = 6;

`ifdef SPI_NOTE_RX_CHECKSUM_EN
    localparam int FRAME_BYTES = 7;
`else
    localparam int FRAME_BYTES = 6;
`endif
    localparam int FRAME_BITS = FRAME_BYTES * 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK,
        ST_COMMIT
    } rx_state_t;

    typedef logic [FRAME_BITS-1:0] frame_t;

    // Byte 0 is the first byte on the wire, so it sits at the MSB end.
    function automatic logic [7:0] frame_byte(input frame_t f, input int n);
        return f[FRAME_BITS-1-8*n -: 8];
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer with rise/fall detection for one SPI input.
// Used identically with or without SPI_NOTE_RX_CHECKSUM_EN.
module spi_input_sync #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;
    logic [STAGES:0]   fill;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {STAGES{INIT}};
            prev  <= INIT;
            fill  <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
            fill  <= {fill[STAGES-1:0], 1'b1};
        end
    end

    // Edges only count once both compared samples came from the pin,
    // so a line held low through reset does not look like a falling edge.
    assign q    = chain[STAGES-1];
    assign rise = fill[STAGES] & q & ~prev;
    assign fall = fill[STAGES] & ~q & prev;

endmodule

// File: rtl/spi_note_receiver.sv
// SPI mode-0 note command receiver: shifts in a frame, validates, commits.
// Define SPI_NOTE_RX_CHECKSUM_EN for 56-bit frames with an XOR checksum byte.
module spi_note_receiver
    import synth_pkg::*;
#(
    parameter int NUM_VOICES  = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_sclk,
    input  logic                i_cs_n,
    input  logic                i_mosi,
    output logic                o_SPI_flag,
    output logic                o_SPI_note_status,
    output logic [VEL_W-1:0]    o_SPI_velocity,
    output logic [VOICE_W-1:0]  o_SPI_voice_index,
    output logic [TUNING_W-1:0] o_SPI_tuning_code,
    output logic                o_frame_error,
    output logic [7:0]          o_error_count
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    logic sclk_q, sclk_rise, sclk_fall;
    logic cs_q, cs_rise, cs_fall;
    logic mosi_q, mosi_rise, mosi_fall;
    logic unused;

    spi_input_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk_sync (
        .clk(i_clk), .reset(i_reset), .d(i_sclk),
        .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_input_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs_sync (
        .clk(i_clk), .reset(i_reset), .d(i_cs_n),
        .q(cs_q), .rise(cs_rise), .fall(cs_fall)
    );

    spi_input_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi_sync (
        .clk(i_clk), .reset(i_reset), .d(i_mosi),
        .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused = ^{sclk_q, sclk_fall, cs_q, mosi_rise, mosi_fall};

    rx_state_t        state;
    frame_t           shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             idx_ok;
    logic             frame_ok;

    assign idx_ok = {1'b0, frame_byte(shreg, BYTE_VOICE)} < 9'(NUM_VOICES);

`ifdef SPI_NOTE_RX_CHECKSUM_EN
    logic [7:0] csum;
    assign csum = frame_byte(shreg, 0) ^ frame_byte(shreg, 1)
                ^ frame_byte(shreg, 2) ^ frame_byte(shreg, 3)
                ^ frame_byte(shreg, 4) ^ frame_byte(shreg, 5);
    assign frame_ok = idx_ok && (frame_byte(shreg, BYTE_CSUM) == csum);
`else
    assign frame_ok = idx_ok;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state             <= ST_IDLE;
            shreg             <= '0;
            bit_cnt           <= '0;
            o_SPI_flag        <= 1'b0;
            o_SPI_note_status <= 1'b0;
            o_SPI_velocity    <= '0;
            o_SPI_voice_index <= '0;
            o_SPI_tuning_code <= '0;
            o_frame_error     <= 1'b0;
            o_error_count     <= '0;
        end else begin
            o_SPI_flag    <= 1'b0;
            o_frame_error <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cs_fall && !cs_rise) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        state         <= ST_IDLE;
                        o_frame_error <= 1'b1;
                        o_error_count <= sat_inc(o_error_count);
                    end else if (sclk_rise) begin
                        shreg   <= {shreg[FRAME_BITS-2:0], mosi_q};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (frame_ok) begin
                        state             <= ST_COMMIT;
                        o_SPI_flag        <= 1'b1;
                        o_SPI_note_status <= shreg[FRAME_BITS-1];
                        o_SPI_velocity    <= shreg[FRAME_BITS-2 -: VEL_W];
                        o_SPI_voice_index <= frame_byte(shreg, BYTE_VOICE);
                        o_SPI_tuning_code <=
                            shreg[FRAME_BITS-1-8*BYTE_TUNE -: TUNING_W];
                    end else begin
                        state         <= ST_IDLE;
                        o_frame_error <= 1'b1;
                        o_error_count <= sat_inc(o_error_count);
                    end
                end
                ST_COMMIT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_note_receiver.sv
// Directed bench for spi_note_receiver with a command-level reference model.
// Honours SPI_NOTE_RX_CHECKSUM_EN for frame length and the checksum scenario.
module tb_spi_note_receiver;

    localparam int NV   = 16;
    localparam int HALF = 4;
    localparam int LAT  = 4;
`ifdef SPI_NOTE_RX_CHECKSUM_EN
    localparam int FB = 56;
`else
    localparam int FB = 48;
`endif

    typedef struct packed {
        logic        st;
        logic [6:0]  vel;
        logic [7:0]  idx;
        logic [31:0] tune;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        flag, st, ferr;
    logic [6:0]  vel;
    logic [7:0]  idx, ecnt;
    logic [31:0] tune;

    spi_note_receiver #(.NUM_VOICES(NV), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_reset(rst), .i_sclk(sclk), .i_cs_n(cs_n),
        .i_mosi(mosi), .o_SPI_flag(flag), .o_SPI_note_status(st),
        .o_SPI_velocity(vel), .o_SPI_voice_index(idx),
        .o_SPI_tuning_code(tune), .o_frame_error(ferr),
        .o_error_count(ecnt)
    );

    always #5 clk = ~clk;

    cmd_t exp_q[$];
    cmd_t held, popped, c;
    int   exp_err = 0;
    int   mcnt = 0;
    int   asserts = 0;
    int   fails = 0;
    int   cyc = 0;
    int   mark = 0;
    bit   lat_armed = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        asserts++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Command semantics from the byte layout: ctrl, voice, 4 tuning bytes.
    function automatic cmd_t decode(input logic [47:0] p);
        cmd_t r;
        r.st   = p[47];
        r.vel  = p[46:40];
        r.idx  = p[39:32];
        r.tune = p[31:0];
        return r;
    endfunction

    function automatic logic [63:0] frame(input logic [47:0] p);
`ifdef SPI_NOTE_RX_CHECKSUM_EN
        logic [7:0] x;
        x = p[47:40] ^ p[39:32] ^ p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
        return {8'h00, p, x};
`else
        return {16'h0000, p};
`endif
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [63:0] d, input int n,
                              input bit track);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = d[i];
            wait_n(HALF);
            sclk = 1'b1;
            if (track && i == 0) begin
                mark = cyc;
                lat_armed = 1'b1;
            end
            wait_n(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic send(input logic [63:0] d, input int n, input bit track);
        cs_n = 1'b0;
        wait_n(HALF);
        shift_bits(d, n, track);
        wait_n(HALF);
        cs_n = 1'b1;
        wait_n(2 * HALF);
    endtask

    task automatic send_cmd(input logic [47:0] p);
        cmd_t e;
        e = decode(p);
        if (e.idx < NV) exp_q.push_back(e);
        else exp_err++;
        send(frame(p), FB, e.idx < NV);
    endtask

    task automatic pending(input string tag);
        chk({tag, "_flags_pending"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_errors_pending"}, 64'(exp_err), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            held = '0;
            mcnt = 0;
        end else begin
            if (flag) begin
                if (exp_q.size() == 0) begin
                    asserts++;
                    fails++;
                    $display("FAIL unexpected_flag actual=1 required=0");
                end else begin
                    popped = exp_q.pop_front();
                    held = popped;
                end
                if (lat_armed) begin
                    chk("flag_latency", 64'(cyc - mark), 64'(LAT));
                    lat_armed = 1'b0;
                end
            end
            if (ferr) begin
                if (exp_err == 0) begin
                    asserts++;
                    fails++;
                    $display("FAIL unexpected_error actual=1 required=0");
                end else begin
                    exp_err--;
                end
                if (mcnt < 255) mcnt++;
            end
            chk("cmd_outputs", 64'({st, vel, idx, tune}), 64'(held));
            chk("error_count", 64'(ecnt), 64'(mcnt));
        end
    end

    initial begin
        wait_n(5);
        rst = 1'b0;
        wait_n(5);
        chk("rst_flag", 64'(flag), 64'd0);
        chk("rst_ferr", 64'(ferr), 64'd0);
        chk("rst_cmd", 64'({st, vel, idx, tune}), 64'd0);
        chk("rst_cnt", 64'(ecnt), 64'd0);

        // Hand-decoded note-on: E4 -> on, velocity 0x64.
        c = '{st: 1'b1, vel: 7'h64, idx: 8'd3, tune: 32'h0012_3456};
        exp_q.push_back(c);
        send(frame(48'hE4_03_00_12_34_56), FB, 1'b1);
        pending("noteon");
        chk("noteon_st", 64'(st), 64'd1);
        chk("noteon_vel", 64'(vel), 64'h64);
        chk("noteon_idx", 64'(idx), 64'd3);
        chk("noteon_tune", 64'(tune), 64'h0012_3456);

        exp_err++;
        send(frame(48'h81_05_AA_BB_CC_DD) >> (FB - 20), 20, 1'b0);
        pending("short");
        chk("short_cnt", 64'(ecnt), 64'd1);
        chk("short_tune_held", 64'(tune), 64'h0012_3456);

        send_cmd(48'h80_20_00_00_00_01);
        pending("badidx");
        chk("badidx_cnt", 64'(ecnt), 64'd2);
        chk("badidx_idx_held", 64'(idx), 64'd3);

        send_cmd(48'h00_0F_FF_FF_FF_FF);
        send_cmd(48'h7F_10_12_34_56_78);
        pending("boundary");
        chk("idx15_idx", 64'(idx), 64'd15);
        chk("idx15_st", 64'(st), 64'd0);
        chk("idx16_cnt", 64'(ecnt), 64'd3);

        send_cmd(48'h9A_05_0A_0B_0C_0D);
        send_cmd(48'hFF_07_80_00_00_01);
        pending("b2b");
        chk("b2b_st", 64'(st), 64'd1);
        chk("b2b_vel", 64'(vel), 64'h7F);
        chk("b2b_idx", 64'(idx), 64'd7);
        chk("b2b_tune", 64'(tune), 64'h8000_0001);

        exp_q.push_back(decode(48'h1C_09_01_02_03_04));
        send((frame(48'h1C_09_01_02_03_04) << 5) | 64'b10110, FB + 5, 1'b0);
        pending("extra_sclk");
        chk("extra_tune", 64'(tune), 64'h0102_0304);

`ifdef SPI_NOTE_RX_CHECKSUM_EN
        // XOR of E4 03 00 12 34 56 is 0x97.
        exp_err++;
        send({8'h00, 48'hE4_03_00_12_34_56, 8'h00}, 56, 1'b0);
        pending("csum_bad");
        chk("csum_bad_cnt", 64'(ecnt), 64'd4);
        exp_q.push_back(decode(48'hE4_03_00_12_34_56));
        send({8'h00, 48'hE4_03_00_12_34_56, 8'h97}, 56, 1'b1);
        pending("csum_good");
        chk("csum_good_tune", 64'(tune), 64'h0012_3456);
`endif

        for (int k = 0; k < 300; k++) begin
            exp_err++;
            send(64'b10, 2, 1'b0);
        end
        pending("sat");
        chk("sat_cnt", 64'(ecnt), 64'd255);

        cs_n = 1'b0;
        wait_n(HALF);
        shift_bits(frame(48'hE4_03_00_12_34_56) >> (FB - 10), 10, 1'b0);
        rst = 1'b1;
        wait_n(3);
        cs_n = 1'b1;
        wait_n(2);
        rst = 1'b0;
        wait_n(4 * HALF);
        chk("rst_mid_cnt", 64'(ecnt), 64'd0);
        chk("rst_mid_cmd", 64'({st, vel, idx, tune}), 64'd0);
        send_cmd(48'hC1_02_DE_AD_BE_EF);
        pending("after_rst");
        chk("after_rst_vel", 64'(vel), 64'h41);
        chk("after_rst_tune", 64'(tune), 64'hDEAD_BEEF);
        chk("after_rst_cnt", 64'(ecnt), 64'd0);

        wait_n(10);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule
